// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-number width and the register-match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 16;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // True when an operand that is actually read matches a pending destination.
    function automatic logic reg_hit(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; ENABLE=0 ties it to zero.
module sat_counter #(
    parameter int WIDTH  = 8,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = (count == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ENABLE && inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, branch,
// multi-cycle data memory and memory-wait timeout, plus perf counters.
//
//   state       | meaning
//   ------------+--------------------------------------------------
//   HZ_RUN      | pipeline flowing, no outstanding data-memory wait
//   HZ_MEM_WAIT | MEM access pending without ack, front stages held
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_re,
    input  logic [REG_W-1:0] ex_rf_dst,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             wb_stall,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         state_next;
    logic              memwait;
    logic              loaduse;
    logic              branch;
    logic              rs_hit;
    logic              rt_hit;
    logic              wait_inc;
    logic              wait_clr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stall_inc;
    logic              flush_inc;

    // Hazard terms
    assign memwait = mem_req & ~mem_ack;
    assign rs_hit  = reg_hit(id_use_rs, id_rs, ex_rf_dst);
    assign rt_hit  = reg_hit(id_use_rt, id_rt, ex_rf_dst);
    assign loaduse = ex_mem_re & (ex_rf_dst != REG_ZERO) & (rs_hit | rt_hit);
    assign branch  = ex_branch_taken & ~memwait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A dropped mem_req while waiting is treated like an ack.
    always_comb begin
        state_next = state;
        case (state)
            HZ_RUN: begin
                if (memwait) begin
                    state_next = HZ_MEM_WAIT;
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_ack || !mem_req) begin
                    state_next = HZ_RUN;
                end
            end
            default: state_next = HZ_RUN;
        endcase
    end

    always_comb begin
        pc_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        wb_stall  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        wb_flush  = 1'b0;
        if (!rst) begin
            if (memwait) begin
                pc_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
                wb_flush  = 1'b1;
            end else if (branch) begin
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
            end else if (loaduse) begin
                pc_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_flush  = 1'b1;
            end
        end
    end

    // Wait length: entering the wait loads 1, every further wait cycle adds 1,
    // leaving the wait clears it.
    assign wait_inc = (state_next == HZ_MEM_WAIT);
    assign wait_clr = rst | (state_next == HZ_RUN);

    sat_counter #(
        .WIDTH  (WAIT_W),
        .ENABLE (1'b1)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (wait_clr),
        .inc    (wait_inc),
        .count  (wait_cnt)
    );

    // Sticky: set on the edge at which the wait count becomes TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (wait_inc && (wait_cnt == TIMEOUT_M1)) begin
            mem_timeout <= 1'b1;
        end
    end

    assign stall_inc = pc_stall;
    assign flush_inc = ex_flush & branch;

    sat_counter #(
        .WIDTH  (CNT_W),
        .ENABLE (1'b1)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (stall_inc),
        .count  (stall_cycles)
    );

    sat_counter #(
        .WIDTH  (CNT_W),
        .ENABLE (1'b1)
    ) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (flush_inc),
        .count  (flush_events)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the `stall`/`flush` inputs of the PC, ID, EX, MEM and WB stage registers, and resolves four hazards:
- load-use data hazards;
- taken branches/jumps resolved in EX;
- multi-cycle data-memory accesses;
- a memory-wait timeout.

It also keeps saturating stall/flush performance counters. It sits beside the datapath and reads the destination/control fields already carried in the stage registers.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.
- `TIMEOUT`, 255: MEM_WAIT cycles before `mem_timeout` asserts; range 1..65535.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID
- `id_use_rs`, `id_use_rt`  in  1 each  the ID instruction actually reads rs / rt
- `ex_mem_re`  in  1  the EX instruction is a load
- `ex_rf_dst`  in  5  destination register of the EX instruction
- `ex_branch_taken`  in  1  the branch/jump in EX redirects the PC this cycle
- `mem_req`  in  1  the MEM instruction accesses data memory (re|we)
- `mem_ack`  in  1  data memory completes the access this cycle
- `pc_stall`, `id_stall`, `ex_stall`, `mem_stall`, `wb_stall`  out  1 each  hold the corresponding register
- `id_flush`, `ex_flush`, `mem_flush`, `wb_flush`  out  1 each  clear the corresponding register to a bubble
- `mem_timeout`  out  1  sticky: a memory wait exceeded `TIMEOUT`
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `pc_stall`=1
- `flush_events`  out  `CNT_W`  saturating count of cycles with `ex_flush`=1 caused by a branch

## Operation
- FSM states are RUN and MEM_WAIT. The stall/flush outputs are combinational from the state and inputs; the FSM, wait counter, timeout flag and perf counters are registered.
- Hazard terms:
  - memwait = `mem_req` & ~`mem_ack`.
  - loaduse = `ex_mem_re` & (`ex_rf_dst`≠0) & ((`id_use_rs` & `id_rs`==`ex_rf_dst`) | (`id_use_rt` & `id_rt`==`ex_rf_dst`)).
- Priority, highest first: memwait > branch > loaduse.
  1. memwait:
     - `pc_stall`=`id_stall`=`ex_stall`=`mem_stall`=1 and `wb_flush`=1 (bubble into WB). All other flushes are 0.
     - The branch is held in EX and re-evaluated once the pipeline advances.
  2. branch (`ex_branch_taken` & ~memwait):
     - `id_flush`=`ex_flush`=1; no stalls.
     - The PC takes the target. The wrong-path ID instruction is discarded, so loaduse is ignored.
  3. loaduse (no memwait, no branch):
     - `pc_stall`=`id_stall`=1 and `ex_flush`=1 (one bubble).
     - The following cycle the load is in MEM and loaduse clears by itself.
- `wb_stall` and `mem_flush` are always 0.
- FSM transitions:
  - RUN → MEM_WAIT on memwait; the wait counter loads 1.
  - MEM_WAIT → RUN on `mem_ack`. The ack cycle itself has no memwait stall, so the pipeline advances that cycle.
  - In MEM_WAIT, `mem_req` falling without `mem_ack` is a protocol error. It is treated as an ack: return to RUN.
- Timeout:
  - In MEM_WAIT the wait counter increments each cycle and saturates.
  - When the counter reaches `TIMEOUT`, `mem_timeout` sets and stays set until `rst`. The stall continues regardless.
- Counters saturate at all-ones and never wrap.
- Reset:
  - State RUN, wait counter 0, `mem_timeout`=0, both perf counters 0.
  - While `rst`=1, all stall and flush outputs are forced to 0; the stage registers reset themselves.
  - Reset in MEM_WAIT returns to RUN the next edge.

## Timing
- Combinational latency is 0: stall/flush respond in the same cycle as the hazard inputs.
- A hazard with no intervening stall costs the following fixed number of cycles:
  - loaduse: exactly 1 bubble.
  - branch: 2 squashed instructions.
  - memwait: n stall cycles for an ack arriving n cycles after the first `mem_req`.
- `stall_cycles` and `flush_events` update at the clock edge ending the counted cycle and are visible the next cycle.
- `mem_timeout` rises at the edge at which the wait counter equals `TIMEOUT`.
- Single-cycle memory (`mem_req`&`mem_ack` in the same cycle) gives no stall and no state change.

## Structure
- A shared package (alongside the existing PCPU defines) holds:
  - the FSM state encoding `HZ_RUN`=0 and `HZ_MEM_WAIT`=1;
  - the register-number width (5);
  - the zero-register constant.
- One natural sub-module, `sat_counter` (parameters width and enable; ports clk, rst, inc, count). It is instantiated twice for the perf counters and once for the wait counter.
- The hazard compares and the priority mux stay in the top module.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_re`=1, `ex_rf_dst`=8, `id_rs`=8, `id_use_rs`=1 for one cycle.
  - Response: `pc_stall`=`id_stall`=`ex_flush`=1 for exactly 1 cycle; `stall_cycles` goes 0→1.
  - Same stimulus with `ex_rf_dst`=0, or with `id_use_rs`=0 → no stall.
- Branch:
  - Stimulus: `ex_branch_taken`=1 together with an active loaduse.
  - Response: `id_flush`=`ex_flush`=1, `pc_stall`=0, `flush_events`=1.
- Memory wait:
  - Stimulus: `mem_req`=1, `mem_ack` low for 3 cycles then high.
  - Response: stalls plus `wb_flush` for 3 cycles, 0 on the ack cycle; state returns to RUN; `stall_cycles`=3.
- Memory wait with branch:
  - Stimulus: memwait and `ex_branch_taken` asserted together for 2 cycles, then ack.
  - Response: no `ex_flush` during the wait; `id_flush`/`ex_flush` assert on the ack cycle.
- Timeout:
  - Stimulus: `TIMEOUT`=4 and `mem_ack` held low for 6 cycles.
  - Response: `mem_timeout` rises at the 4th wait edge and stays 1 after the ack; a `rst` pulse clears it.
- Saturation and reset:
  - Stimulus: `CNT_W`=3 with 10 load-use stalls.
  - Response: `stall_cycles`=7.
  - Stimulus: `rst` asserted in MEM_WAIT with `mem_req` held high.
  - Response: while `rst`=1, all stall/flush outputs are 0 and the counters are 0. After `rst` deasserts, the FSM restarts from RUN.
